// File: rtl/ct_fadd_pkg.sv
// rtl/ct_fadd_pkg.sv - shared types and constants for the FADD writeback path
// Exception-flag layout and the writeback buffer entry record.
package ct_fadd_pkg;

   localparam int FFLAG_W     = 5;
   localparam int FFLAG_NV    = 4;
   localparam int FFLAG_DZ    = 3;
   localparam int FFLAG_OF    = 2;
   localparam int FFLAG_UF    = 1;
   localparam int FFLAG_NX    = 0;
   localparam int FADD_DATA_W = 64;
   localparam int FADD_PREG_W = 7;

   typedef struct packed {
      logic [FADD_DATA_W-1:0] data;
      logic [FFLAG_W-1:0]     fflags;
      logic [FADD_PREG_W-1:0] preg;
   } fadd_wb_entry_t;

endpackage

// File: rtl/ct_fadd_wb_fifo_entry.sv
// rtl/ct_fadd_wb_fifo_entry.sv - one writeback buffer storage slot
// Loads the offered entry on write enable; clears on reset.
import ct_fadd_pkg::*;

module ct_fadd_wb_fifo_entry (
   input  logic           ex1_pipe_clk,
   input  logic           cpurst_b,
   input  logic           we_i,
   input  fadd_wb_entry_t entry_i,
   output fadd_wb_entry_t entry_o
);

   fadd_wb_entry_t entry_q;

   always_ff @(posedge ex1_pipe_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         entry_q <= '0;
      end else if (we_i) begin
         entry_q <= entry_i;
      end
   end

   assign entry_o = entry_q;

endmodule

// File: rtl/ct_fadd_wb_buf.sv
// rtl/ct_fadd_wb_buf.sv - in-order skid buffer between FADD EX3 and FP writeback
// Optional sticky fflags accumulator enabled by FADD_WB_FFLAGS_ACC_EN.
import ct_fadd_pkg::*;

module ct_fadd_wb_buf #(
   parameter int DEPTH  = 2,
   parameter int PREG_W = FADD_PREG_W
) (
   input  logic                   ex1_pipe_clk,
   input  logic                   cpurst_b,
   input  logic                   fadd_forward_r_vld,
   input  logic [FADD_DATA_W-1:0] fadd_forward_result,
   input  logic [FFLAG_W-1:0]     fadd_ereg_ex3_result,
   input  logic [PREG_W-1:0]      ex3_dst_preg,
   input  logic                   wb_ready,
   input  logic                   rtu_flush,
   input  logic                   fflags_clr,
   output logic                   wb_vld,
   output logic [FADD_DATA_W-1:0] wb_data,
   output logic [PREG_W-1:0]      wb_preg,
   output logic [FFLAG_W-1:0]     wb_fflags,
   output logic                   fadd_wb_full,
   output logic                   wb_ovfl_err,
   output logic [FFLAG_W-1:0]     fflags_acc
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovfl_q, ovfl_d;

   logic             full_raw;
   logic             pop;
   logic             push_ok;
   logic [DEPTH-1:0] entry_we;
   fadd_wb_entry_t   wr_entry;
   fadd_wb_entry_t   head;
   fadd_wb_entry_t   entry_q [DEPTH];

   assign full_raw     = (cnt_q == DEPTH_C);
   assign wb_vld       = (cnt_q != '0);
   assign pop          = wb_vld & wb_ready;
   // A full buffer still takes a push when its head leaves in the same cycle.
   assign push_ok      = fadd_forward_r_vld & (~full_raw | pop);
   assign fadd_wb_full = full_raw & ~wb_ready;

   assign wr_entry.data   = fadd_forward_result;
   assign wr_entry.fflags = fadd_ereg_ex3_result;
   assign wr_entry.preg   = FADD_PREG_W'(ex3_dst_preg);

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      assign entry_we[g] = push_ok & ~rtu_flush & (wr_ptr_q == PTR_W'(g));

      ct_fadd_wb_fifo_entry u_entry (
         .ex1_pipe_clk (ex1_pipe_clk),
         .cpurst_b     (cpurst_b),
         .we_i         (entry_we[g]),
         .entry_i      (wr_entry),
         .entry_o      (entry_q[g])
      );
   end

   assign head      = entry_q[rd_ptr_q];
   assign wb_data   = head.data;
   assign wb_fflags = head.fflags;
   assign wb_preg   = PREG_W'(head.preg);

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      ovfl_d   = ovfl_q | (fadd_forward_r_vld & full_raw & ~wb_ready);
      if (rtu_flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge ex1_pipe_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         ovfl_q   <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         ovfl_q   <= ovfl_d;
      end
   end

   assign wb_ovfl_err = ovfl_q;

`ifdef FADD_WB_FFLAGS_ACC_EN
   logic [FFLAG_W-1:0] acc_q, acc_d;

   // A pop squashed by a flush never retired, so its flags are not folded in.
   always_comb begin
      acc_d = acc_q;
      if (pop && !rtu_flush) begin
         acc_d = (fflags_clr ? '0 : acc_q) | head.fflags;
      end else if (fflags_clr) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge ex1_pipe_clk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign fflags_acc = acc_q;
`else
   logic unused_fflags_clr;
   assign unused_fflags_clr = fflags_clr;
   assign fflags_acc        = '0;
`endif

endmodule

// File: tb/tb_ct_fadd_wb_buf.sv
// tb/tb_ct_fadd_wb_buf.sv - self-checking bench for ct_fadd_wb_buf
// Directed scenarios followed by random traffic against a queue reference.
module tb_ct_fadd_wb_buf;

   localparam int DEPTH  = 2;
   localparam int PREG_W = 7;

   logic        ex1_pipe_clk = 1'b0;
   logic        cpurst_b;
   logic        fadd_forward_r_vld;
   logic [63:0] fadd_forward_result;
   logic [4:0]  fadd_ereg_ex3_result;
   logic [6:0]  ex3_dst_preg;
   logic        wb_ready;
   logic        rtu_flush;
   logic        fflags_clr;
   logic        wb_vld;
   logic [63:0] wb_data;
   logic [6:0]  wb_preg;
   logic [4:0]  wb_fflags;
   logic        fadd_wb_full;
   logic        wb_ovfl_err;
   logic [4:0]  fflags_acc;

   always #5 ex1_pipe_clk = ~ex1_pipe_clk;

   ct_fadd_wb_buf #(.DEPTH(DEPTH), .PREG_W(PREG_W)) dut (
      .ex1_pipe_clk         (ex1_pipe_clk),
      .cpurst_b             (cpurst_b),
      .fadd_forward_r_vld   (fadd_forward_r_vld),
      .fadd_forward_result  (fadd_forward_result),
      .fadd_ereg_ex3_result (fadd_ereg_ex3_result),
      .ex3_dst_preg         (ex3_dst_preg),
      .wb_ready             (wb_ready),
      .rtu_flush            (rtu_flush),
      .fflags_clr           (fflags_clr),
      .wb_vld               (wb_vld),
      .wb_data              (wb_data),
      .wb_preg              (wb_preg),
      .wb_fflags            (wb_fflags),
      .fadd_wb_full         (fadd_wb_full),
      .wb_ovfl_err          (wb_ovfl_err),
      .fflags_acc           (fflags_acc)
   );

   typedef struct {
      logic [63:0] d;
      logic [4:0]  f;
      logic [6:0]  p;
   } ent_t;

   ent_t       mq[$];
   logic       m_ovfl;
   logic [4:0] m_acc;
   int         tests = 0;
   int         fails = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      cpurst_b             = 1'b0;
      fadd_forward_r_vld   = 1'b0;
      fadd_forward_result  = '0;
      fadd_ereg_ex3_result = '0;
      ex3_dst_preg         = '0;
      wb_ready             = 1'b0;
      rtu_flush            = 1'b0;
      fflags_clr           = 1'b0;
      mq.delete();
      m_ovfl = 1'b0;
      m_acc  = '0;
      #13;
      cpurst_b = 1'b1;
      @(posedge ex1_pipe_clk);
      #1;
   endtask

   // Drive one cycle, check outputs against the reference, then advance the reference.
   task automatic step(input logic vld, input logic [63:0] d, input logic [4:0] f,
                       input logic [6:0] p, input logic rdy, input logic fl, input logic clr);
      ent_t hd;
      logic pop;
      logic full;
      fadd_forward_r_vld   = vld;
      fadd_forward_result  = d;
      fadd_ereg_ex3_result = f;
      ex3_dst_preg         = p;
      wb_ready             = rdy;
      rtu_flush            = fl;
      fflags_clr           = clr;
      @(negedge ex1_pipe_clk);
      full = (mq.size() == DEPTH);
      chk("wb_vld", 64'(wb_vld), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("wb_data", wb_data, mq[0].d);
         chk("wb_fflags", 64'(wb_fflags), 64'(mq[0].f));
         chk("wb_preg", 64'(wb_preg), 64'(mq[0].p));
      end
      chk("fadd_wb_full", 64'(fadd_wb_full), 64'(full && !rdy));
      chk("wb_ovfl_err", 64'(wb_ovfl_err), 64'(m_ovfl));
      chk("fflags_acc", 64'(fflags_acc), 64'(m_acc));

      pop = (mq.size() != 0) && rdy;
      hd  = '{d: '0, f: '0, p: '0};
      if (pop) hd = mq[0];
      if (vld && full && !rdy) m_ovfl = 1'b1;
      if (fl) begin
         mq.delete();
      end else begin
         if (pop) void'(mq.pop_front());
         if (vld && !(full && !rdy)) mq.push_back('{d: d, f: f, p: p});
      end
`ifdef FADD_WB_FFLAGS_ACC_EN
      if (pop && !fl) m_acc = (clr ? 5'd0 : m_acc) | hd.f;
      else if (clr) m_acc = 5'd0;
`endif
      @(posedge ex1_pipe_clk);
      #1;
   endtask

   initial begin
      do_reset();

      @(negedge ex1_pipe_clk);
      chk("rst_wb_vld", 64'(wb_vld), 64'd0);
      chk("rst_wb_data", wb_data, 64'd0);
      chk("rst_wb_fflags", 64'(wb_fflags), 64'd0);
      chk("rst_wb_preg", 64'(wb_preg), 64'd0);
      chk("rst_full", 64'(fadd_wb_full), 64'd0);
      chk("rst_ovfl", 64'(wb_ovfl_err), 64'd0);
      chk("rst_acc", 64'(fflags_acc), 64'd0);
      @(posedge ex1_pipe_clk);
      #1;

      // single push, one-cycle latency, immediate pop
      step(1'b1, 64'h3FF0000000000000, 5'b00001, 7'd5, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);

      // fill, overflow drop, drain
      step(1'b1, 64'hAAAA_0000_0000_0001, 5'b00010, 7'd10, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hBBBB_0000_0000_0002, 5'b00100, 7'd11, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'hCCCC_0000_0000_0003, 5'b01000, 7'd12, 1'b0, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);

      // full with simultaneous pop and push
      step(1'b1, 64'h1111_0000_0000_0001, 5'b00001, 7'd20, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h2222_0000_0000_0002, 5'b00010, 7'd21, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h3333_0000_0000_0003, 5'b00100, 7'd22, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b0, 1'b0, 1'b0);

      // flush with concurrent pop
      step(1'b1, 64'h4444_0000_0000_0004, 5'b10000, 7'd30, 1'b0, 1'b0, 1'b0);
      step(1'b1, 64'h5555_0000_0000_0005, 5'b01000, 7'd31, 1'b0, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b1, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);

      // flag accumulation and clearing
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 64'h6666_0000_0000_0006, 5'b10000, 7'd40, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'h7777_0000_0000_0007, 5'b00001, 7'd41, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 64'h8888_0000_0000_0008, 5'b00100, 7'd42, 1'b0, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b0, 1'b0, 1'b0);

      // pointer wrap with back-to-back push/pop
      do_reset();
      for (int i = 0; i < 10; i++) begin
         step(1'b1, {$urandom(), $urandom()}, 5'($urandom()), 7'($urandom()), 1'b1, 1'b0, 1'b0);
      end
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b0, 1'b0, 1'b0);

      // random traffic
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(($urandom() % 4) != 0, {$urandom(), $urandom()}, 5'($urandom()), 7'($urandom()),
              ($urandom() % 3) != 0, ($urandom() % 32) == 0, ($urandom() % 16) == 0);
      end
      step(1'b0, 64'h0, 5'b0, 7'd0, 1'b1, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
